// File: rtl/axi_lite_sram_slave_if.sv
// ============================================================================
//  Module      : axi_lite_sram_slave_if
//  Description : AXI-lite channel bundle between an initiator and the SRAM
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axi_lite_sram_slave.sv
// ============================================================================
//  Module      : axi_lite_sram_slave
//  Description : AXI-lite SRAM responder with independent read/write paths
//                and a programmable request-to-response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    DELAY      = 1
) (
  input wire                   i_clk,
  input wire                   i_rst_n,
  axi_lite_sram_slave_if.slave axi
);

  localparam int                    c_strb_w   = DATA_WIDTH / 8;
  localparam int                    c_idx_w    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_span     = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [7:0]            c_cnt_init = 8'(DELAY - 1);
  localparam logic [1:0]            c_okay     = 2'b00;
  localparam logic [1:0]            c_slverr   = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- write
  w_state_t              r_wstate, w_wstate_nxt;
  logic                  r_aw_got, r_w_got;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_strb_w-1:0]   r_wstrb;
  logic [7:0]            r_wcnt;
  logic [1:0]            r_bresp;
  logic                  w_awready, w_wready, w_wcap, w_commit;
  logic                  w_aw_hs, w_w_hs;
  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic                  w_wr_ok;
  logic [c_idx_w-1:0]    w_wr_idx;

  assign w_wr_off = r_awaddr - BASE_ADDR;
  assign w_wr_ok  = (r_awaddr >= BASE_ADDR) && (w_wr_off < c_span);
  assign w_wr_idx = w_wr_off[2 +: c_idx_w];
  assign w_aw_hs  = axi.awvalid && w_awready;
  assign w_w_hs   = axi.wvalid && w_wready;

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_wcap       = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = !r_aw_got;
        w_wready  = !r_w_got;
        // AW and W may arrive together or in either order
        if ((r_aw_got || (axi.awvalid && w_awready)) &&
            (r_w_got  || (axi.wvalid  && w_wready))) begin
          w_wcap       = 1'b1;
          w_wstate_nxt = W_WAIT;
        end
      end
      W_WAIT: begin
        if (r_wcnt == 8'd0) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wcnt   <= 8'd0;
      r_bresp  <= c_okay;
    end else begin
      if (w_aw_hs) begin
        r_awaddr <= axi.awaddr;
        r_aw_got <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata <= axi.wdata;
        r_wstrb <= axi.wstrb;
        r_w_got <= 1'b1;
      end
      if (w_wcap) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_wcnt   <= c_cnt_init;
      end else if (r_wstate == W_WAIT && r_wcnt != 8'd0) begin
        r_wcnt <= r_wcnt - 8'd1;
      end
      if (w_commit) begin
        r_bresp <= w_wr_ok ? c_okay : c_slverr;
      end
    end
  end

  // Array is deliberately not reset; lanes are written independently
  always_ff @(posedge i_clk) begin
    if (w_commit && w_wr_ok) begin
      for (int i = 0; i < c_strb_w; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_wr_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign axi.awready = w_awready;
  assign axi.wready  = w_wready;
  assign axi.bvalid  = (r_wstate == W_RESP);
  assign axi.bresp   = r_bresp;

  // ----------------------------------------------------------------- read
  r_state_t              r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_rcnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_rcap, w_rload;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic                  w_rd_ok;
  logic [c_idx_w-1:0]    w_rd_idx;

  assign w_rd_off = r_araddr - BASE_ADDR;
  assign w_rd_ok  = (r_araddr >= BASE_ADDR) && (w_rd_off < c_span);
  assign w_rd_idx = w_rd_off[2 +: c_idx_w];

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rcap       = 1'b0;
    w_rload      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (axi.arvalid) begin
          w_rcap       = 1'b1;
          w_rstate_nxt = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_rcnt == 8'd0) begin
          w_rload      = 1'b1;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (axi.rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // rdata loads with a non-blocking read, so a same-edge commit is not seen
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_araddr <= '0;
      r_rcnt   <= 8'd0;
      r_rdata  <= '0;
      r_rresp  <= c_okay;
    end else begin
      if (w_rcap) begin
        r_araddr <= axi.araddr;
        r_rcnt   <= c_cnt_init;
      end else if (r_rstate == R_WAIT && r_rcnt != 8'd0) begin
        r_rcnt <= r_rcnt - 8'd1;
      end
      if (w_rload) begin
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rresp <= w_rd_ok ? c_okay : c_slverr;
      end
    end
  end

  assign axi.arready = (r_rstate == R_IDLE);
  assign axi.rvalid  = (r_rstate == R_RESP);
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_sram_slave.sv
// ============================================================================
//  Module      : tb_axi_lite_sram_slave
//  Description : Bench for two responders (latency 1 and 4) with a
//                transaction-level reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_sram_slave;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0][31:0] awaddr, wdata, araddr, rdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]       arvalid, arready, rvalid, rready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    axi_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();
    assign axi.awaddr  = awaddr[k];
    assign axi.awvalid = awvalid[k];
    assign axi.wdata   = wdata[k];
    assign axi.wstrb   = wstrb[k];
    assign axi.wvalid  = wvalid[k];
    assign axi.bready  = bready[k];
    assign axi.araddr  = araddr[k];
    assign axi.arvalid = arvalid[k];
    assign axi.rready  = rready[k];
    assign awready[k]  = axi.awready;
    assign wready[k]   = axi.wready;
    assign bresp[k]    = axi.bresp;
    assign bvalid[k]   = axi.bvalid;
    assign arready[k]  = axi.arready;
    assign rdata[k]    = axi.rdata;
    assign rresp[k]    = axi.rresp;
    assign rvalid[k]   = axi.rvalid;

    axi_lite_sram_slave #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .DEPTH     (1024),
      .BASE_ADDR (32'h8000_0000),
      .DELAY     ((k == 0) ? 1 : 4)
    ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .axi    (axi)
    );
  end

  function automatic int dly(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit inr(input logic [31:0] a);
    return (a >= 32'h8000_0000) && ((a - 32'h8000_0000) < 32'd4096);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h8000_0000) >> 2) & 1023;
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): actual %h, required %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: each accepted request owns an absolute
  // due edge; responses persist until their ready is seen at an edge.
  logic [31:0] mem_m [2][1024];
  bit          aw_h [2], w_h [2], b_show [2], r_show [2];
  int          wr_due [2] = '{-1, -1};
  int          rd_due [2] = '{-1, -1};
  logic [31:0] wa [2], wd [2], ra [2], exp_rdata [2];
  logic [3:0]  ws [2];
  logic [1:0]  exp_bresp [2], exp_rresp [2];
  bit          chk_en = 1'b0;

  initial begin
    int nxt;
    nxt = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          if (!rst_n) begin
            aw_h[k] = 0; w_h[k] = 0; b_show[k] = 0; r_show[k] = 0;
            wr_due[k] = -1; rd_due[k] = -1;
            exp_rdata[k] = 32'h0; exp_bresp[k] = 2'b00; exp_rresp[k] = 2'b00;
            check("rst_rdata", k, rdata[k], 32'h0);
            check("rst_bresp", k, 32'(bresp[k]), 32'h0);
            check("rst_rresp", k, 32'(rresp[k]), 32'h0);
          end
          check("awready", k, 32'(awready[k]), 32'(!aw_h[k] && wr_due[k] < 0 && !b_show[k]));
          check("wready",  k, 32'(wready[k]),  32'(!w_h[k]  && wr_due[k] < 0 && !b_show[k]));
          check("bvalid",  k, 32'(bvalid[k]),  32'(b_show[k]));
          check("arready", k, 32'(arready[k]), 32'(rd_due[k] < 0 && !r_show[k]));
          check("rvalid",  k, 32'(rvalid[k]),  32'(r_show[k]));
          if (b_show[k]) check("bresp", k, 32'(bresp[k]), 32'(exp_bresp[k]));
          if (r_show[k]) begin
            check("rdata", k, rdata[k], exp_rdata[k]);
            check("rresp", k, 32'(rresp[k]), 32'(exp_rresp[k]));
          end
          if (rst_n) begin
            // read side first: a same-edge load sees pre-commit contents
            if (r_show[k]) begin
              if (rready[k]) r_show[k] = 0;
            end else if (rd_due[k] >= 0) begin
              if (rd_due[k] == nxt) begin
                exp_rdata[k] = inr(ra[k]) ? mem_m[k][widx(ra[k])] : 32'h0;
                exp_rresp[k] = inr(ra[k]) ? 2'b00 : 2'b10;
                r_show[k]    = 1;
                rd_due[k]    = -1;
              end
            end else if (arvalid[k]) begin
              ra[k]     = araddr[k];
              rd_due[k] = nxt + dly(k);
            end
            if (b_show[k]) begin
              if (bready[k]) b_show[k] = 0;
            end else if (wr_due[k] >= 0) begin
              if (wr_due[k] == nxt) begin
                if (inr(wa[k]))
                  for (int b = 0; b < 4; b++)
                    if (ws[k][b]) mem_m[k][widx(wa[k])][8*b +: 8] = wd[k][8*b +: 8];
                exp_bresp[k] = inr(wa[k]) ? 2'b00 : 2'b10;
                b_show[k]    = 1;
                wr_due[k]    = -1;
              end
            end else begin
              if (awvalid[k] && !aw_h[k]) begin aw_h[k] = 1; wa[k] = awaddr[k]; end
              if (wvalid[k] && !w_h[k]) begin w_h[k] = 1; wd[k] = wdata[k]; ws[k] = wstrb[k]; end
              if (aw_h[k] && w_h[k]) begin
                aw_h[k] = 0; w_h[k] = 0;
                wr_due[k] = nxt + dly(k);
              end
            end
          end
        end
      end
      nxt++;
    end
  end

  // Starts #1 after an edge. bl: cycles from capture edge to bvalid visible;
  // rl: cycles from capture edge until both readies are back.
  task automatic write_txn(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int wgap,
                           output int bl, output int rl, output logic [1:0] resp);
    bl = -1; rl = -1; resp = 2'b11;
    awaddr[k] = a; wdata[k] = d; wstrb[k] = s; awvalid[k] = 1'b1;
    if (wgap == 0) wvalid[k] = 1'b1;
    tick;
    awvalid[k] = 1'b0;
    if (wgap == 0) begin
      wvalid[k] = 1'b0;
    end else begin
      repeat (wgap - 1) tick;
      wvalid[k] = 1'b1;
      tick;
      wvalid[k] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      if (bvalid[k] && bl < 0) begin bl = n; resp = bresp[k]; end
      if (awready[k] && wready[k]) begin rl = n; break; end
      tick;
    end
    check("wr_ready_return", k, 32'(rl), 32'(dly(k) + 1));
  endtask

  task automatic read_txn(input int k, input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
    lat = -1; d = 32'hxxxx_xxxx; resp = 2'b11;
    araddr[k] = a; arvalid[k] = 1'b1; rready[k] = (hold == 0);
    tick;
    arvalid[k] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (rvalid[k]) begin lat = n; d = rdata[k]; resp = rresp[k]; break; end
      tick;
    end
    check("rd_latency", k, 32'(lat), 32'(dly(k)));
    if (lat >= 0 && hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        check("bp_arready_low", k, 32'(arready[k]), 32'd0);
        check("bp_rvalid_held", k, 32'(rvalid[k]), 32'd1);
        tick;
      end
      rready[k] = 1'b1;
      tick;
      check("bp_arready_back", k, 32'(arready[k]), 32'd1);
    end else if (lat >= 0) begin
      tick;
    end
    rready[k] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual timeout, required completion");
    $fatal(1);
  end

  initial begin
    int          bl, rl, lat, lat2;
    logic [1:0]  rs, rs2;
    logic [31:0] rd;

    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready = '1; rready = '1;

    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_bvalid",  k, 32'(bvalid[k]),  32'd0);
      check("reset_rvalid",  k, 32'(rvalid[k]),  32'd0);
      check("reset_awready", k, 32'(awready[k]), 32'd1);
      check("reset_wready",  k, 32'(wready[k]),  32'd1);
      check("reset_arready", k, 32'(arready[k]), 32'd1);
      check("reset_rdata",   k, rdata[k],        32'h0);
    end
    rst_n = 1'b1;
    tick;

    // Latency 1, AW and W together
    write_txn(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, bl, rl, rs);
    check("d1_bvalid_lat", 0, 32'(bl), 32'd1);
    check("d1_bresp",      0, 32'(rs), 32'd0);
    check("d1_ready_low",  0, 32'(rl), 32'd2);
    read_txn(0, 32'h8000_0010, 0, rd, rs, lat);
    check("d1_rdata", 0, rd, 32'hDEAD_BEEF);

    // Latency 4, W three cycles behind AW, partial strobe
    write_txn(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, bl, rl, rs);
    check("d4_full_bresp", 1, 32'(rs), 32'd0);
    write_txn(1, 32'h8000_0010, 32'h0000_1234, 4'b0011, 3, bl, rl, rs);
    check("d4_bvalid_cycle", 1, 32'(3 + bl), 32'd7);
    check("d4_bresp",        1, 32'(rs), 32'd0);
    read_txn(1, 32'h8000_0010, 0, rd, rs, lat);
    check("d4_rdata",   1, rd, 32'hDEAD_1234);
    check("d4_rd_lat",  1, 32'(lat), 32'd4);

    // Read backpressure
    read_txn(1, 32'h8000_0010, 5, rd, rs, lat);
    check("bp_rdata", 1, rd, 32'hDEAD_1234);
    check("bp_rresp", 1, 32'(rs), 32'd0);

    // Out of range on both sides of the window
    write_txn(0, 32'h8000_0000, 32'hA5A5_5A5A, 4'hF, 0, bl, rl, rs);
    read_txn(0, 32'h7FFF_FFFC, 0, rd, rs, lat);
    check("oor_rd_resp", 0, 32'(rs), 32'd2);
    check("oor_rd_data", 0, rd, 32'h0);
    write_txn(0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, bl, rl, rs);
    check("oor_wr_resp", 0, 32'(rs), 32'd2);
    read_txn(0, 32'h8000_0000, 0, rd, rs, lat);
    check("oor_word0", 0, rd, 32'hA5A5_5A5A);

    // Strobe patterns, address low bits ignored
    write_txn(0, 32'h8000_0000, 32'h1234_5678, 4'b0000, 0, bl, rl, rs);
    check("strb0_bresp", 0, 32'(rs), 32'd0);
    read_txn(0, 32'h8000_0000, 0, rd, rs, lat);
    check("strb0_data", 0, rd, 32'hA5A5_5A5A);
    write_txn(0, 32'h8000_0000, 32'h1122_3344, 4'b1010, 0, bl, rl, rs);
    read_txn(0, 32'h8000_0003, 0, rd, rs, lat);
    check("strb1010_data", 0, rd, 32'h11A5_335A);

    // Commit and read load on the same edge
    write_txn(1, 32'h8000_0040, 32'h1111_1111, 4'hF, 0, bl, rl, rs);
    fork
      write_txn(1, 32'h8000_0040, 32'h0000_0005, 4'hF, 0, bl, rl, rs);
      read_txn(1, 32'h8000_0040, 0, rd, rs2, lat2);
    join
    check("coll_old", 1, rd, 32'h1111_1111);
    read_txn(1, 32'h8000_0040, 0, rd, rs, lat);
    check("coll_new", 1, rd, 32'h0000_0005);

    // Reset while a write is waiting for its commit
    awaddr[1] = 32'h8000_0040; wdata[1] = 32'hBAD0_BAD0; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    tick;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("rel_awready", k, 32'(awready[k]), 32'd1);
      check("rel_wready",  k, 32'(wready[k]),  32'd1);
      check("rel_arready", k, 32'(arready[k]), 32'd1);
    end
    for (int n = 0; n < 8; n++) begin
      check("rst_no_bvalid", 1, 32'(bvalid[1]), 32'd0);
      tick;
    end
    read_txn(1, 32'h8000_0040, 0, rd, rs, lat);
    check("rst_old_data", 1, rd, 32'h0000_0005);

    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
